mux_1: RTL and testbench

// - Full-adder slice built on an 8:1 multiplexer, with registered outputs.
// - s[2:0] = {a,b,cin} is the select. sum = data input i[s]; carry = majority(a,b,cin), taken from an

---
 rtl/mux_1.sv | 58 +++++
 tb/tb_mux_1.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_1.sv
// rtl/mux_1.sv - full-adder slice on an 8:1 mux with registered sum/carry outputs
// Optional feature macro: MUX1_SUM_CHECK_EN (adds registered sum_err output)
module mux_1 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i7,
    input  logic       i6,
    input  logic       i5,
    input  logic       i4,
    input  logic       i3,
    input  logic       i2,
    input  logic       i1,
    input  logic       i0,
    input  logic [2:0] s,
`ifdef MUX1_SUM_CHECK_EN
    output logic       sum_err,
`endif
    output logic       sum,
    output logic       carry
);

    // Majority of {a,b,cin} expressed as a constant mux table indexed by s
    localparam logic [7:0] CARRY_TABLE = 8'b1110_1000;

    logic [7:0] i_bus;
    logic       sum_d;
    logic       carry_d;

    assign i_bus   = {i7, i6, i5, i4, i3, i2, i1, i0};
    assign sum_d   = i_bus[s];
    assign carry_d = CARRY_TABLE[s];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= 1'b0;
            carry <= 1'b0;
        end else begin
            sum   <= sum_d;
            carry <= carry_d;
        end
    end

`ifdef MUX1_SUM_CHECK_EN
    // Flags a data pattern that disagrees with a true full-adder sum for this select
    logic sum_err_d;

    assign sum_err_d = sum_d ^ (^s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_err <= 1'b0;
        end else begin
            sum_err <= sum_err_d;
        end
    end
`endif

endmodule

// File: tb/tb_mux_1.sv
// tb/tb_mux_1.sv - scoreboard bench for mux_1 with a behavioural full-adder/mux model
module tb_mux_1;

    logic       clk;
    logic       rst_n;
    logic [7:0] iv;
    logic [2:0] s;
    logic       sum;
    logic       carry;
    logic       sum_err;

    int n_cmp;
    int n_err;
    int cyc;

    typedef struct {
        logic exp_sum;
        logic exp_carry;
        logic exp_err;
        int   cyc;
    } entry_t;

    entry_t q[$];

`ifndef MUX1_SUM_CHECK_EN
    assign sum_err = 1'b0;
`endif

    mux_1 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .i7    (iv[7]),
        .i6    (iv[6]),
        .i5    (iv[5]),
        .i4    (iv[4]),
        .i3    (iv[3]),
        .i2    (iv[2]),
        .i1    (iv[1]),
        .i0    (iv[0]),
        .s     (s),
`ifdef MUX1_SUM_CHECK_EN
        .sum_err (sum_err),
`endif
        .sum   (sum),
        .carry (carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: arithmetic view of the full adder and of the mux select
    function automatic entry_t model(input logic [7:0] data, input logic [2:0] sel);
        entry_t e;
        int a, b, c, ones, idx;
        a    = int'(sel[2]);
        b    = int'(sel[1]);
        c    = int'(sel[0]);
        ones = a + b + c;
        idx  = 4 * a + 2 * b + c;
        e.exp_sum   = ((int'(data) / (1 << idx)) % 2) == 1;
        e.exp_carry = ones >= 2;
        e.exp_err   = e.exp_sum ^ ((ones % 2) == 1);
        e.cyc       = cyc;
        return e;
    endfunction

    task automatic apply(input logic [7:0] data, input logic [2:0] sel);
        @(posedge clk);
        #1;
        iv = data;
        s  = sel;
        q.push_back(model(data, sel));
    endtask

    // Monitor: an entry matures once a rising edge has passed since it was applied
    initial begin
        entry_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc < cyc) begin
                e = q.pop_front();
                chk("sb_sum", sum, e.exp_sum);
                chk("sb_carry", carry, e.exp_carry);
`ifdef MUX1_SUM_CHECK_EN
                chk("sb_sum_err", sum_err, e.exp_err);
`endif
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        iv    = 8'($urandom);
        s     = 3'($urandom);

        // Reset before any clock edge, then across edges
        #2;
        chk("rst_pre_sum", sum, 1'b0);
        chk("rst_pre_carry", carry, 1'b0);
        chk("rst_pre_err", sum_err, 1'b0);
        iv = 8'hFF;
        s  = 3'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_post_sum", sum, 1'b0);
        chk("rst_post_carry", carry, 1'b0);
        chk("rst_post_err", sum_err, 1'b0);

        // Latency: release between edges, outputs follow only at the next edge
        #2;
        rst_n = 1'b1;
        #1;
        chk("lat_hold_sum", sum, 1'b0);
        chk("lat_hold_carry", carry, 1'b0);
        @(posedge clk);
        #1;
        chk("lat_sum", sum, 1'b1);
        chk("lat_carry", carry, 1'b1);

        // Full-adder sweep
        for (int k = 0; k < 8; k++) apply(8'h96, 3'(k));

        // Pure mux
        apply(8'b0000_0100, 3'd2);
        apply(8'b0000_0100, 3'd5);

        // Async reset mid-run
        apply(8'hFF, 3'd7);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("mid_pre_sum", sum, 1'b1);
        chk("mid_pre_carry", carry, 1'b1);
        rst_n = 1'b0;
        q.delete();
        #1;
        chk("mid_rst_sum", sum, 1'b0);
        chk("mid_rst_carry", carry, 1'b0);
        chk("mid_rst_err", sum_err, 1'b0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_rel_sum", sum, 1'b1);
        chk("mid_rel_carry", carry, 1'b1);

        // Check-feature vector followed by random vectors
        apply(8'hFF, 3'd0);
        for (int k = 0; k < 20; k++) apply(8'($urandom), 3'($urandom_range(0, 7)));

        for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
        @(negedge clk);
        #1;
        n_cmp++;
        if (q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d entries left, expected 0", q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
